// File: rtl/d_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int A_WIDTH_DEF    = 32;
  localparam int INDEX_BITS_DEF = 6;
  localparam int TAG_BITS_DEF   = A_WIDTH_DEF - INDEX_BITS_DEF - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

endpackage

// File: rtl/d_cache_ctrl_if.sv
// CPU-side and memory-side bus of the data cache; the cache uses the slave view.
interface d_cache_ctrl_if #(
  parameter int A_WIDTH = 32
);

  logic [A_WIDTH-1:0] p_a;
  logic [31:0]        p_din;
  logic               p_strobe;
  logic               p_rw;
  logic               uncached;
  logic [31:0]        p_dout;
  logic               p_ready;

  logic [A_WIDTH-1:0] m_a;
  logic [31:0]        m_dout;
  logic [31:0]        m_din;
  logic               m_strobe;
  logic               m_rw;
  logic               m_ready;

  logic [15:0]        hit_cnt;
  logic [15:0]        miss_cnt;

  modport slave (
    input  p_a, p_din, p_strobe, p_rw, uncached, m_din, m_ready,
    output p_dout, p_ready, m_a, m_dout, m_strobe, m_rw, hit_cnt, miss_cnt
  );

  modport master (
    output p_a, p_din, p_strobe, p_rw, uncached, m_din, m_ready,
    input  p_dout, p_ready, m_a, m_dout, m_strobe, m_rw, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/d_cache_ctrl_line_store.sv
// Valid/tag/data arrays of the cache: one combinational read port, one write port.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_BITS   = TAG_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic [INDEX_BITS-1:0] i_rdIndex,
  output logic                  o_valid,
  output logic [TAG_BITS-1:0]   o_tag,
  output logic [31:0]           o_data,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_wrIndex,
  input  logic [TAG_BITS-1:0]   i_wrTag,
  input  logic [31:0]           i_wrData
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [31:0]         r_data [LINES];

  // Only the valid bits need a reset; stale tag/data are harmless behind them.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wrIndex] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wrIndex]  <= i_wrTag;
      r_data[i_wrIndex] <= i_wrData;
    end
  end

  assign o_valid = r_valid[i_rdIndex];
  assign o_tag   = r_tag[i_rdIndex];
  assign o_data  = r_data[i_rdIndex];

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with hit/miss counters.
module d_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int A_WIDTH    = A_WIDTH_DEF,
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input logic            clk,
  input logic            clrn,
  d_cache_ctrl_if.slave  bus
);

  localparam int TAG_BITS = A_WIDTH - INDEX_BITS - 2;

  state_t r_state;
  state_t w_next;

  logic [A_WIDTH-1:0]    r_addr;
  logic [31:0]           r_data;
  logic                  r_uncached;
  logic [15:0]           r_hitCnt;
  logic [15:0]           r_missCnt;

  logic                  w_idle;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_reqTag;
  logic                  w_reqUncached;
  logic                  w_lineValid;
  logic [TAG_BITS-1:0]   w_lineTag;
  logic [31:0]           w_lineData;
  logic                  w_hit;
  logic                  w_we;
  logic [31:0]           w_wrData;
  logic                  w_latch;
  logic                  w_cntHit;
  logic                  w_cntMiss;
  logic                  w_pReady;
  logic [31:0]           w_pDout;

  // In IDLE the lookup follows the live CPU address; during a transaction it follows the latched one.
  assign w_idle        = (r_state == ST_IDLE);
  assign w_index       = w_idle ? bus.p_a[INDEX_BITS+1:2]      : r_addr[INDEX_BITS+1:2];
  assign w_reqTag      = w_idle ? bus.p_a[A_WIDTH-1:INDEX_BITS+2] : r_addr[A_WIDTH-1:INDEX_BITS+2];
  assign w_reqUncached = w_idle ? bus.uncached : r_uncached;
  assign w_hit         = w_lineValid & (w_lineTag == w_reqTag) & ~w_reqUncached;

  dcache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lineStore (
    .clk       (clk),
    .clrn      (clrn),
    .i_rdIndex (w_index),
    .o_valid   (w_lineValid),
    .o_tag     (w_lineTag),
    .o_data    (w_lineData),
    .i_we      (w_we),
    .i_wrIndex (w_index),
    .i_wrTag   (w_reqTag),
    .i_wrData  (w_wrData)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_cntHit  = 1'b0;
    w_cntMiss = 1'b0;
    w_we      = 1'b0;
    w_wrData  = r_data;
    w_pReady  = 1'b0;
    w_pDout   = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.p_strobe) begin
          if (bus.p_rw) begin
            w_latch = 1'b1;
            w_next  = ST_WR;
          end else if (w_hit) begin
            w_pReady = 1'b1;
            w_pDout  = w_lineData;
            w_cntHit = 1'b1;
          end else begin
            w_latch   = 1'b1;
            w_cntMiss = ~bus.uncached;
            w_next    = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (bus.m_ready) begin
          w_pReady = 1'b1;
          w_pDout  = bus.m_din;
          w_we     = ~r_uncached;
          w_wrData = bus.m_din;
          w_next   = ST_IDLE;
        end
      end
      ST_WR: begin
        // Write-through on a hit only; a write miss never allocates.
        if (bus.m_ready) begin
          w_pReady = 1'b1;
          w_we     = w_hit;
          w_wrData = r_data;
          w_next   = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_uncached <= 1'b0;
    end else if (w_latch) begin
      r_addr     <= bus.p_a;
      r_data     <= bus.p_din;
      r_uncached <= bus.uncached;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_hitCnt  <= '0;
      r_missCnt <= '0;
    end else begin
      if (w_cntHit && (r_hitCnt != 16'hFFFF)) begin
        r_hitCnt <= r_hitCnt + 16'd1;
      end
      if (w_cntMiss && (r_missCnt != 16'hFFFF)) begin
        r_missCnt <= r_missCnt + 16'd1;
      end
    end
  end

  // Memory strobe comes straight from the state so it drops the cycle after m_ready.
  assign bus.m_strobe = ~w_idle;
  assign bus.m_rw     = (r_state == ST_WR);
  assign bus.m_a      = r_addr;
  assign bus.m_dout   = r_data;
  assign bus.p_ready  = w_pReady;
  assign bus.p_dout   = w_pDout;
  assign bus.hit_cnt  = r_hitCnt;
  assign bus.miss_cnt = r_missCnt;

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Self-checking bench for d_cache_ctrl: directed scenarios plus random traffic against a cache model.
module tb_d_cache_ctrl;

  localparam int MEM_CYCLES = 7;

  logic clk;
  logic clrn;
  int   total;
  int   bad;

  d_cache_ctrl_if #(.A_WIDTH(32)) bus ();

  d_cache_ctrl #(
    .A_WIDTH    (32),
    .INDEX_BITS (6)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  // Model: per line, the word address it holds; memory as a sparse word map.
  bit          modelValid [64];
  logic [29:0] modelLine  [64];
  logic [31:0] modelData  [64];
  logic [31:0] memWords   [logic [29:0]];
  logic [15:0] hitCount;
  logic [15:0] missCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 64; i++) modelValid[i] = 1'b0;
    hitCount  = '0;
    missCount = '0;
  endtask

  task automatic idleCycle(input logic spurious);
    bus.p_strobe = 1'b0;
    bus.m_ready  = spurious;
    bus.m_din    = $urandom;
    @(negedge clk);
    checkOutput("idleNoReady", 32'(bus.p_ready), 32'd0);
    nextCycle();
    bus.m_ready = 1'b0;
    bus.m_din   = 'z;
    checkOutput("idleNoStrobe", 32'(bus.m_strobe), 32'd0);
  endtask

  // One CPU request starting at the current cycle; plays the memory side for misses/writes.
  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [31:0] wdata, input logic unc);
    int          idx;
    logic [29:0] wa;
    logic        hitExp;
    logic [31:0] rdExp;
    wa     = addr[31:2];
    idx    = int'(addr[7:2]);
    hitExp = !rw && !unc && modelValid[idx] && (modelLine[idx] == wa);
    bus.p_a      = addr;
    bus.p_din    = wdata;
    bus.p_rw     = rw;
    bus.uncached = unc;
    bus.p_strobe = 1'b1;
    @(negedge clk);
    if (hitExp) begin
      checkOutput("hitReady", 32'(bus.p_ready), 32'd1);
      checkOutput("hitData", bus.p_dout, modelData[idx]);
      checkOutput("hitNoStrobe", 32'(bus.m_strobe), 32'd0);
      if (hitCount != 16'hFFFF) hitCount++;
      nextCycle();
      bus.p_strobe = 1'b0;
      checkOutput("hitCnt", 32'(bus.hit_cnt), 32'(hitCount));
      checkOutput("hitStrobeAfter", 32'(bus.m_strobe), 32'd0);
      return;
    end
    checkOutput("reqNoReady", 32'(bus.p_ready), 32'd0);
    if (!rw && !unc && missCount != 16'hFFFF) missCount++;
    if (!memWords.exists(wa)) memWords[wa] = $urandom;
    rdExp = unc ? $urandom : memWords[wa];
    for (int cyc = 1; cyc <= MEM_CYCLES; cyc++) begin
      nextCycle();
      bus.p_a      = $urandom;
      bus.p_din    = $urandom;
      bus.p_strobe = 1'($urandom);
      bus.p_rw     = 1'($urandom);
      bus.uncached = 1'($urandom);
      if (cyc == MEM_CYCLES) begin
        bus.m_ready = 1'b1;
        bus.m_din   = rw ? $urandom : rdExp;
      end
      @(negedge clk);
      checkOutput("memStrobe", 32'(bus.m_strobe), 32'd1);
      checkOutput("memRw", 32'(bus.m_rw), 32'(rw));
      checkOutput("memAddr", bus.m_a, addr);
      if (rw) checkOutput("memWdata", bus.m_dout, wdata);
      checkOutput("cpuReady", 32'(bus.p_ready), 32'(cyc == MEM_CYCLES));
      if (cyc == MEM_CYCLES && !rw) checkOutput("missData", bus.p_dout, rdExp);
    end
    nextCycle();
    bus.m_ready  = 1'b0;
    bus.m_din    = 'z;
    bus.p_strobe = 1'b0;
    if (rw) begin
      memWords[wa] = wdata;
      if (!unc && modelValid[idx] && modelLine[idx] == wa) modelData[idx] = wdata;
    end else if (!unc) begin
      modelValid[idx] = 1'b1;
      modelLine[idx]  = wa;
      modelData[idx]  = rdExp;
    end
    checkOutput("strobeDrop", 32'(bus.m_strobe), 32'd0);
    checkOutput("missCnt", 32'(bus.miss_cnt), 32'(missCount));
    checkOutput("hitCntHold", 32'(bus.hit_cnt), 32'(hitCount));
  endtask

  initial begin
    logic [31:0] addr;
    total        = 0;
    bad          = 0;
    clrn         = 1'b0;
    bus.p_a      = '0;
    bus.p_din    = '0;
    bus.p_strobe = 1'b0;
    bus.p_rw     = 1'b0;
    bus.uncached = 1'b0;
    bus.m_din    = 'z;
    bus.m_ready  = 1'b0;
    clearModel();

    @(negedge clk);
    checkOutput("rstReady", 32'(bus.p_ready), 32'd0);
    checkOutput("rstStrobe", 32'(bus.m_strobe), 32'd0);
    checkOutput("rstRw", 32'(bus.m_rw), 32'd0);
    checkOutput("rstAddr", bus.m_a, 32'd0);
    checkOutput("rstDout", bus.m_dout, 32'd0);
    checkOutput("rstPdout", bus.p_dout, 32'd0);
    checkOutput("rstHits", 32'(bus.hit_cnt), 32'd0);
    checkOutput("rstMisses", 32'(bus.miss_cnt), 32'd0);
    nextCycle();
    clrn = 1'b1;
    nextCycle();

    memWords[30'h10] = 32'h1234_5678;
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0080, 32'hCAFE_0080, 1'b0);
    applyStimulus(1'b1, 32'h0000_0080, 32'hCAFE_0081, 1'b1);
    applyStimulus(1'b0, 32'h0000_0080, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0140, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1'b0);

    // Reset three cycles into a miss: the transaction must vanish and the cache empty.
    bus.p_a      = 32'h0000_AB00;
    bus.p_rw     = 1'b0;
    bus.uncached = 1'b0;
    bus.p_strobe = 1'b1;
    nextCycle();
    bus.p_strobe = 1'b0;
    nextCycle();
    nextCycle();
    #2;
    checkOutput("preRstStrobe", 32'(bus.m_strobe), 32'd1);
    clrn = 1'b0;
    #1;
    checkOutput("abortStrobe", 32'(bus.m_strobe), 32'd0);
    checkOutput("abortReady", 32'(bus.p_ready), 32'd0);
    checkOutput("abortAddr", bus.m_a, 32'd0);
    checkOutput("abortMisses", 32'(bus.miss_cnt), 32'd0);
    clearModel();
    nextCycle();
    checkOutput("abortStrobeHeld", 32'(bus.m_strobe), 32'd0);
    clrn = 1'b1;
    idleCycle(1'b1);
    idleCycle(1'b0);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0000_0040, 32'h0, 1'b0);

    for (int n = 0; n < 160; n++) begin
      logic [5:0] idx;
      case ($urandom_range(0, 3))
        0: idx = 6'h00;
        1: idx = 6'h01;
        2: idx = 6'h10;
        default: idx = 6'h20;
      endcase
      addr = ({$urandom_range(0, 3)} << 8) | ({26'd0, idx} << 2) | {30'd0, 2'($urandom)};
      if ($urandom_range(0, 4) == 0) idleCycle(1'($urandom));
      applyStimulus($urandom_range(0, 9) < 3, addr, $urandom, $urandom_range(0, 6) == 0);
    end

    checkOutput("finalHits", 32'(bus.hit_cnt), 32'(hitCount));
    checkOutput("finalMisses", 32'(bus.miss_cnt), 32'(missCount));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
